// File: rtl/led_arbiter_pkg.sv
// Shared types and helpers for the LED bank arbiter.
// Build option: LED_ARBITER_FIXED_PRIO_EN (see led_arbiter_pick).
package led_arbiter_pkg;

   // Arbiter FSM states
   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_HOLD = 1'b1
   } arb_state_t;

   // Width of the hold counter: clog2(hold), never less than one bit
   function automatic int cnt_width(input int hold);
      int w;
      w = $clog2(hold);
      if (w < 1) w = 1;
      return w;
   endfunction

endpackage

// File: rtl/led_arbiter_if.sv
// Requester/LED-side bundle of the LED bank arbiter.
// The arbiter takes the slave view; pattern sources and the board see master.
interface led_arbiter_if #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8
);
   logic [NREQ-1:0]       REQ;
   logic [NREQ*WIDTH-1:0] PAT;
   logic [NREQ-1:0]       GNT;
   logic [WIDTH-1:0]      LED;
   logic                  BUSY;
   logic [NREQ-1:0]       DONE;

   modport slave (
      input  REQ, PAT,
      output GNT, LED, BUSY, DONE
   );

   modport master (
      output REQ, PAT,
      input  GNT, LED, BUSY, DONE
   );
endinterface

// File: rtl/led_arbiter_pick.sv
// Combinational winner search for the LED bank arbiter.
// Default: round-robin search upward from ptr_i, wrapping NREQ-1 -> 0.
// LED_ARBITER_FIXED_PRIO_EN: lowest asserted index wins, ptr_i ignored.
module led_arbiter_pick
   import led_arbiter_pkg::*;
#(
   parameter int NREQ = 4,
   localparam int IW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [IW-1:0]   ptr_i,
   output logic [IW-1:0]   win_o,
   output logic            valid_o
);

`ifdef LED_ARBITER_FIXED_PRIO_EN
   logic unused_ptr;
   assign unused_ptr = ^ptr_i;

   // Scan downward so the lowest asserted index is written last and wins
   always_comb begin
      win_o = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (req_i[k]) win_o = IW'(k);
      end
   end
`else
   // Scan offsets downward from ptr so the smallest offset is written last and wins
   always_comb begin
      win_o = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (req_i[(int'(ptr_i) + k) % NREQ]) win_o = IW'((int'(ptr_i) + k) % NREQ);
      end
   end
`endif

   assign valid_o = |req_i;

endmodule

// File: rtl/led_arbiter.sv
// Time-shares one WIDTH-bit LED bank among NREQ pattern sources.
// A grant lasts HOLD cycles or ends when the grantee drops its request;
// there is always one idle cycle (carrying the DONE pulse) between grants.
// Build option: LED_ARBITER_FIXED_PRIO_EN selects fixed priority instead of round-robin.
module led_arbiter
   import led_arbiter_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int NREQ  = 4,
   parameter int HOLD  = 1024
) (
   input  logic        CLK,
   input  logic        RST,
   led_arbiter_if.slave bus
);

   localparam int IW = $clog2(NREQ);
   localparam int CW = cnt_width(HOLD);
   localparam logic [CW-1:0] CNT_LAST = CW'(HOLD - 1);

   arb_state_t        state_q;
   logic [NREQ-1:0]   gnt_q;
   logic [WIDTH-1:0]  led_q;
   logic              busy_q;
   logic [NREQ-1:0]   done_q;
   logic [IW-1:0]     ptr_q;
   logic [CW-1:0]     cnt_q;
   logic [IW-1:0]     g_q;

   logic [IW-1:0]     win_idx;
   logic              win_valid;
   logic              release_d;
   logic [WIDTH-1:0]  pat_arr [NREQ];

   // Slice the flat pattern bus into one entry per requester
   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_pat
         assign pat_arr[gi] = bus.PAT[gi*WIDTH +: WIDTH];
      end
   endgenerate

   led_arbiter_pick #(.NREQ(NREQ)) u_pick (
      .req_i   (bus.REQ),
      .ptr_i   (ptr_q),
      .win_o   (win_idx),
      .valid_o (win_valid)
   );

   // Grant ends on withdrawal or when the last hold cycle is reached
   assign release_d = !bus.REQ[g_q] || (cnt_q == CNT_LAST);

`ifndef LED_ARBITER_FIXED_PRIO_EN
   logic [IW-1:0] ptr_d;
   // Next search start is the requester just after the one released
   assign ptr_d = (g_q == IW'(NREQ - 1)) ? '0 : g_q + 1'b1;
`endif

   // Arbiter FSM with all outputs registered
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= ARB_IDLE;
         gnt_q   <= '0;
         led_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
         g_q     <= '0;
      end else begin
         done_q <= '0;
         case (state_q)
            ARB_IDLE: begin
               if (win_valid) begin
                  gnt_q   <= NREQ'(1) << win_idx;
                  g_q     <= win_idx;
                  led_q   <= pat_arr[win_idx];
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= ARB_HOLD;
               end
            end
            ARB_HOLD: begin
               if (release_d) begin
                  gnt_q   <= '0;
                  done_q  <= NREQ'(1) << g_q;
                  busy_q  <= 1'b0;
                  state_q <= ARB_IDLE;
`ifndef LED_ARBITER_FIXED_PRIO_EN
                  ptr_q   <= ptr_d;
`endif
               end else begin
                  cnt_q <= cnt_q + 1'b1;
                  led_q <= pat_arr[g_q];
               end
            end
            default: state_q <= ARB_IDLE;
         endcase
      end
   end

   assign bus.GNT  = gnt_q;
   assign bus.LED  = led_q;
   assign bus.BUSY = busy_q;
   assign bus.DONE = done_q;

endmodule

// File: tb/tb_led_arbiter.sv
// Directed bench for led_arbiter with NREQ=4, WIDTH=8, HOLD=16.
// Expectations switch with LED_ARBITER_FIXED_PRIO_EN where the builds differ.
module tb_led_arbiter;

   localparam int NREQ  = 4;
   localparam int WIDTH = 8;
   localparam int HOLD  = 16;

   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_err = 0;
   logic [7:0] pat_tb [4];
   logic [3:0] exp_nx;
   int         exp_i;

   led_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

   led_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .HOLD(HOLD)) dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   function automatic logic [3:0] oh(input int i);
      logic [3:0] one;
      one = 4'b0001;
      return one << i;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_pat();
      bus.PAT = {pat_tb[3], pat_tb[2], pat_tb[1], pat_tb[0]};
   endtask

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end else begin
         $display("ok   %s: %0h", tag, got);
      end
   endtask

   task automatic check_outs(input string tag, input logic [3:0] gnt, input logic [7:0] led,
                             input logic busy, input logic [3:0] done);
      check_val({tag, "_gnt"},  32'(bus.GNT),  32'(gnt));
      check_val({tag, "_led"},  32'(bus.LED),  32'(led));
      check_val({tag, "_busy"}, 32'(bus.BUSY), 32'(busy));
      check_val({tag, "_done"}, 32'(bus.DONE), 32'(done));
   endtask

   // Called in the first cycle of a grant; returns in the DONE cycle
   task automatic grant_len(input string tag, input logic [3:0] gnt);
      int n;
      n = 0;
      while (bus.GNT === gnt && n < 40) begin
         n++;
         tick();
      end
      check_val({tag, "_len"},  32'(n),        32'(HOLD));
      check_val({tag, "_done"}, 32'(bus.DONE), 32'(gnt));
      check_val({tag, "_gnt0"}, 32'(bus.GNT),  32'h0);
      check_val({tag, "_busy"}, 32'(bus.BUSY), 32'h0);
   endtask

   initial begin
      // Reset held with every requester asking
      rst     = 1'b1;
      bus.REQ = 4'b1111;
      pat_tb  = '{8'h1E, 8'h2D, 8'h3C, 8'h4B};
      drive_pat();
      tick();
      check_outs("rst1", 4'h0, 8'h00, 1'b0, 4'h0);
      tick();
      check_outs("rst2", 4'h0, 8'h00, 1'b0, 4'h0);
      rst = 1'b0;
      tick();

      // Round-robin (or fixed-priority) rotation with all requests held
      for (int r = 0; r < 5; r++) begin
`ifdef LED_ARBITER_FIXED_PRIO_EN
         exp_i = 0;
`else
         exp_i = r % 4;
`endif
         check_outs($sformatf("rr%0d", r), oh(exp_i), pat_tb[exp_i], 1'b1, 4'h0);
         grant_len($sformatf("rr%0d", r), oh(exp_i));
         if (r == 4) bus.REQ = 4'b0000;
         tick();
      end
      check_outs("rr_idle", 4'h0, pat_tb[0], 1'b0, 4'h0);

      // Single requester: full-length grant and regrant after one idle cycle
      pat_tb[0] = 8'hA5;
      drive_pat();
      bus.REQ = 4'b0001;
      tick();
      check_outs("single", 4'b0001, 8'hA5, 1'b1, 4'h0);
      grant_len("single", 4'b0001);
      tick();
      check_outs("single_regrant", 4'b0001, 8'hA5, 1'b1, 4'h0);
      bus.REQ = 4'b0000;
      tick();
      check_outs("single_rel", 4'h0, 8'hA5, 1'b0, 4'b0001);
      tick();
      check_val("single_idle_done", 32'(bus.DONE), 32'h0);

      // Early release of requester 2 at cnt=5, then pick among 1011
      bus.REQ = 4'b0100;
      tick();
      check_outs("early_gnt", 4'b0100, pat_tb[2], 1'b1, 4'h0);
      repeat (5) tick();
      check_val("early_cnt5_gnt", 32'(bus.GNT), 32'b0100);
      bus.REQ = 4'b1011;
      tick();
      check_outs("early_rel", 4'h0, pat_tb[2], 1'b0, 4'b0100);
`ifdef LED_ARBITER_FIXED_PRIO_EN
      exp_nx = 4'b0001;
`else
      exp_nx = 4'b1000;
`endif
      tick();
      check_val("early_next_gnt",  32'(bus.GNT),  32'(exp_nx));
      check_val("early_next_done", 32'(bus.DONE), 32'h0);
      bus.REQ = 4'b0000;
      tick();
      check_val("early_next_rel", 32'(bus.DONE), 32'(exp_nx));
      tick();

      // Live pattern tracking during a grant
      pat_tb[0] = 8'h01;
      drive_pat();
      bus.REQ = 4'b0001;
      tick();
      check_outs("live_gnt", 4'b0001, 8'h01, 1'b1, 4'h0);
      repeat (4) tick();
      check_val("live_cnt4_led", 32'(bus.LED), 32'h01);
      pat_tb[0] = 8'h02;
      drive_pat();
      tick();
      check_val("live_led", 32'(bus.LED), 32'h02);
      check_val("live_gnt_hold", 32'(bus.GNT), 32'b0001);
      bus.REQ = 4'b0000;
      tick();
      check_val("live_rel", 32'(bus.DONE), 32'b0001);
      tick();

      // Reset in the middle of requester 1's grant
      bus.REQ = 4'b0010;
      tick();
      check_val("midrst_gnt", 32'(bus.GNT), 32'b0010);
      repeat (7) tick();
      rst = 1'b1;
      tick();
      check_outs("midrst", 4'h0, 8'h00, 1'b0, 4'h0);
      rst     = 1'b0;
      bus.REQ = 4'b0011;
      tick();
      check_outs("post_rst", 4'b0001, 8'h02, 1'b1, 4'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/led_arbiter.md
# led_arbiter

Time-shares one WIDTH-bit LED bank among NREQ requesters, each of which supplies its own display pattern. A round-robin arbiter grants the bank to one requester at a time. Each grant lasts HOLD cycles, or ends earlier if the requester withdraws. The block sits between pattern generators (blink counters, status encoders) and the board LED pins, and replaces direct LED drive when several sources compete.

## Interface
- WIDTH, 8: LED bank width.
- NREQ, 4: number of requesters (≥2).
- HOLD, 1024: maximum grant duration in cycles (≥2).

- CLK  in  1  system clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- REQ  in  NREQ  request level per requester; held while the requester wants the LEDs.
- PAT  in  NREQ*WIDTH  requester i pattern is PAT[i*WIDTH +: WIDTH].
- GNT  out  NREQ  registered one-hot grant; all-zero when idle.
- LED  out  WIDTH  registered LED drive.
- BUSY  out  1  high while a grant is active (state ARB_HOLD).
- DONE  out  NREQ  one-cycle, one-hot pulse marking the end of requester i's grant.

## Operation
- States: ARB_IDLE and ARB_HOLD.
- Internal registers:
  - ptr, log2 NREQ bits: round-robin start index.
  - cnt, clog2(HOLD) bits: hold counter.
  - g: index of the current grantee.
- ARB_IDLE with REQ≠0:
  - Winner = first asserted REQ bit found searching upward from ptr, wrapping at NREQ-1→0.
  - At the next edge: GNT ← one-hot(winner), g ← winner, LED ← PAT[winner], cnt ← 0, state ← ARB_HOLD.
- ARB_IDLE with REQ=0: stay idle. LED keeps its last displayed value; GNT = 0.
- ARB_HOLD, each edge, checked in this priority order:
  1. REQ[g]=0 (early release), or cnt = HOLD-1 (expiry): GNT ← 0, DONE ← one-hot(g), ptr ← (g+1) mod NREQ, state ← ARB_IDLE. LED is not updated on this edge.
  2. Otherwise: cnt ← cnt+1, LED ← PAT[g]. The live pattern is tracked, so mid-grant pattern changes are displayed.
- Requests from other requesters during ARB_HOLD are ignored until the block returns to ARB_IDLE. There is no preemption.
- Counter arithmetic is unsigned; cnt never exceeds HOLD-1 and never wraps.
- DONE is cleared on every edge where it is not set.
- A requester that keeps REQ asserted through its own expiry loses the next arbitration round to any other pending requester. If no other requester is pending, it is regranted after the idle cycle.

## Timing
- Reset values: GNT=0, LED=0, BUSY=0, DONE=0, ptr=0, cnt=0, state=ARB_IDLE.
- RST asserted mid-grant returns every register to its reset value at the next edge. No DONE pulse is produced.
- Grant latency: REQ sampled high in ARB_IDLE at edge t gives GNT and LED=PAT[winner] valid after edge t.
- Grant length with REQ held: GNT is high for exactly HOLD cycles.
- Early release: REQ[g] sampled low at edge t clears GNT after edge t.
- DONE is high for the single cycle after the release edge. That cycle is always ARB_IDLE.
- There is exactly one idle cycle between consecutive grants. The next GNT appears one cycle after DONE.
- Pattern-to-LED latency during a grant: 1 cycle.

## Configuration
- LED_ARBITER_FIXED_PRIO_EN defined: the winner is the lowest-index asserted REQ bit. ptr is neither updated nor used.
- LED_ARBITER_FIXED_PRIO_EN undefined: round-robin as described above.
- All other behaviour and timing are identical in both builds.

## Structure
- Package led_arbiter_pkg holds:
  - the state enum (ARB_IDLE, ARB_HOLD);
  - a width helper returning clog2(HOLD), minimum 1.
- Sub-module led_arbiter_pick: purely combinational. Inputs REQ and ptr; outputs winner index and a valid flag. The round-robin search and the fixed-priority search (selected by the macro) live here. The top level holds the FSM, counter and output registers.

## Test plan
Bench parameters: NREQ=4, WIDTH=8, HOLD=16.
- Reset: hold RST for 2 cycles with REQ=4'b1111 → GNT=0, LED=8'h00, BUSY=0, DONE=0 throughout; first grant goes to requester 0 one cycle after RST falls.
- Single requester: REQ=4'b0001, PAT0=8'hA5 held → GNT=4'b0001 for exactly 16 cycles, LED=8'hA5 from the grant edge, DONE=4'b0001 pulsed for 1 cycle, regrant 1 cycle later.
- Round-robin: REQ=4'b1111 held → grant order 0,1,2,3,0; each grant 16 cycles with a 1-cycle gap; DONE pulses 0001, 0010, 0100, 1000 in turn. With LED_ARBITER_FIXED_PRIO_EN defined, requester 0 wins every round.
- Early release: requester 2 granted, REQ[2] dropped when cnt=5 → GNT clears on that edge, DONE=4'b0100 for 1 cycle; with REQ=4'b1011 pending, the next grant goes to requester 3.
- Live pattern: requester 0 granted, PAT0 changes 8'h01→8'h02 at cnt=4 → LED=8'h02 one edge later; GNT unchanged.
- Reset mid-grant: RST pulsed at cnt=7 of requester 1's grant → all outputs 0 next edge, no DONE pulse, ptr=0, so REQ=4'b0011 then grants requester 0.
